// File: rtl/bf_encoder_if.sv
// rtl/bf_encoder_if.sv - handshake bundle between a byte source / word sink and bf_encoder
//
// Purpose: groups the source-byte stream, the packed-word stream and the status flags.
// Signals:
//   in_data[7:0], in_valid, in_last   source -> encoder, ASCII program bytes
//   in_ready                          encoder -> source, byte accepted this cycle
//   out_word[15:0], out_addr[N-3:0]   encoder -> sink, packed opcodes and word address
//   out_valid / out_ready             word handshake
//   done, err_unbalanced, err_overflow sticky status
// Modports: slave = encoder side, master = source/sink side.
interface bf_encoder_if #(
  parameter int N = 8
);
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [15:0]  out_word;
  logic [N-3:0] out_addr;
  logic         out_valid;
  logic         out_ready;
  logic         done;
  logic         err_unbalanced;
  logic         err_overflow;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_word, out_addr, out_valid, done, err_unbalanced, err_overflow
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_word, out_addr, out_valid, done, err_unbalanced, err_overflow
  );
endinterface

// File: rtl/bf_encoder.sv
// rtl/bf_encoder.sv - packs a Brainfuck ASCII program into 16-bit words of 4-bit opcodes
//
// Purpose: accepts source bytes, maps the eight command characters to opcodes, packs four
// opcodes per word (first opcode in the top nibble), emits each full word with its address,
// terminates the program with 0xF halt/pad nibbles, and flags bracket mismatch or overflow.
// Ports:
//   clock  sole clock
//   reset  synchronous, active-high
//   bus    bf_encoder_if.slave (byte stream in, word stream out, done/error flags)
// Parameter N: log2 of program capacity in nibbles (legal N >= 4).
module bf_encoder #(
  parameter int N = 8
) (
  input  logic          clock,
  input  logic          reset,
  bf_encoder_if.slave   bus
);

  localparam logic [2:0] S_FILL  = 3'd0;
  localparam logic [2:0] S_EMIT  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [3:0]   OP_OPEN  = 4'h6;
  localparam logic [3:0]   OP_CLOSE = 4'h7;
  localparam logic [N-1:0] NIB_MAX  = '1;
  localparam logic [N-1:0] ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-3:0] ONE_A    = {{(N-3){1'b0}}, 1'b1};

  logic [2:0]   state;
  logic [1:0]   slot;
  logic [N-1:0] nib_cnt;
  logic [N-1:0] depth;
  logic [15:0]  word;
  logic [N-3:0] addr;
  logic         last_seen;
  logic         err_unb;
  logic         err_ovf;

  logic         is_op;
  logic [3:0]   op;
  logic         accept;
  logic         bad_close;
  logic         no_room;
  logic         bad_end;
  logic [N-1:0] depth_next;
  logic [1:0]   slot_next;
  logic [15:0]  word_ins;
  logic [15:0]  pad_mask;

  always_comb begin
    is_op = 1'b1;
    op    = 4'hF;
    case (bus.in_data)
      8'h3E:   op = 4'h0;  // '>'
      8'h3C:   op = 4'h1;  // '<'
      8'h2B:   op = 4'h2;  // '+'
      8'h2D:   op = 4'h3;  // '-'
      8'h2E:   op = 4'h4;  // '.'
      8'h2C:   op = 4'h5;  // ','
      8'h5B:   op = 4'h6;  // '['
      8'h5D:   op = 4'h7;  // ']'
      default: is_op = 1'b0;
    endcase
  end

  always_comb begin
    accept    = (state == S_FILL) && bus.in_valid;
    bad_close = is_op && (op == OP_CLOSE) && (depth == '0);
    // Keep one nibble free so the halt always fits.
    no_room   = is_op && (nib_cnt == NIB_MAX);

    depth_next = depth;
    if (is_op && op == OP_OPEN) begin
      depth_next = depth + ONE_N;
    end else if (is_op && op == OP_CLOSE) begin
      depth_next = depth - ONE_N;
    end
    // Depth is judged after this byte's own bracket has been applied.
    bad_end = bus.in_last && (depth_next != '0);

    slot_next = is_op ? slot + 2'd1 : slot;

    word_ins = word;
    if (is_op) begin
      case (slot)
        2'd0:    word_ins[15:12] = op;
        2'd1:    word_ins[11:8]  = op;
        2'd2:    word_ins[7:4]   = op;
        default: word_ins[3:0]   = op;
      endcase
    end

    // Slots from slot_next upward receive the 0xF halt/pad nibble.
    case (slot_next)
      2'd0:    pad_mask = 16'hFFFF;
      2'd1:    pad_mask = 16'h0FFF;
      2'd2:    pad_mask = 16'h00FF;
      default: pad_mask = 16'h000F;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FILL;
      slot      <= 2'd0;
      nib_cnt   <= '0;
      depth     <= '0;
      word      <= 16'h0000;
      addr      <= '0;
      last_seen <= 1'b0;
      err_unb   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            if (bad_close) begin
              state   <= S_ERROR;
              err_unb <= 1'b1;
            end else if (no_room) begin
              state   <= S_ERROR;
              err_ovf <= 1'b1;
            end else if (bad_end) begin
              // A word completed by this final byte is dropped with the error.
              state   <= S_ERROR;
              err_unb <= 1'b1;
            end else begin
              depth <= depth_next;
              if (is_op) begin
                word    <= word_ins;
                slot    <= slot_next;
                nib_cnt <= nib_cnt + ONE_N;
              end
              if (is_op && slot == 2'd3) begin
                state     <= S_EMIT;
                last_seen <= bus.in_last;
              end else if (bus.in_last) begin
                state <= S_FLUSH;
                word  <= word_ins | pad_mask;
              end
            end
          end
        end

        S_EMIT: begin
          if (bus.out_ready) begin
            addr <= addr + ONE_A;
            slot <= 2'd0;
            if (last_seen) begin
              // Program ended exactly on a word boundary: a full halt word follows.
              state <= S_FLUSH;
              word  <= 16'hFFFF;
            end else begin
              state <= S_FILL;
              word  <= 16'h0000;
            end
          end
        end

        S_FLUSH: begin
          if (bus.out_ready) begin
            state <= S_DONE;
          end
        end

        default: begin
          // DONE and ERROR hold until reset.
        end
      endcase
    end
  end

  assign bus.in_ready       = (state == S_FILL);
  assign bus.out_valid      = (state == S_EMIT) || (state == S_FLUSH);
  assign bus.out_word       = word;
  assign bus.out_addr       = addr;
  assign bus.done           = (state == S_DONE);
  assign bus.err_unbalanced = err_unb;
  assign bus.err_overflow   = err_ovf;

endmodule

// File: tb/tb_bf_encoder.sv
// tb/tb_bf_encoder.sv - self-checking bench for bf_encoder (N=8 and N=4 instances)
module tb_bf_encoder;
  typedef logic [7:0] u8;
  typedef u8 u8q[$];

  localparam int ST_DONE = 0;
  localparam int ST_UNB  = 1;
  localparam int ST_OVF  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       sel = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  bf_encoder_if #(.N(8)) b8 ();
  bf_encoder_if #(.N(4)) b4 ();

  bf_encoder #(.N(8)) dut8 (.clock(clock), .reset(reset), .bus(b8));
  bf_encoder #(.N(4)) dut4 (.clock(clock), .reset(reset), .bus(b4));

  assign b8.in_data   = in_data;
  assign b8.in_last   = in_last;
  assign b8.in_valid  = in_valid & ~sel;
  assign b8.out_ready = out_ready;
  assign b4.in_data   = in_data;
  assign b4.in_last   = in_last;
  assign b4.in_valid  = in_valid & sel;
  assign b4.out_ready = out_ready;

  logic        m_ir, m_ov, m_done, m_eu, m_eo;
  logic [15:0] m_word;
  logic [7:0]  m_addr;

  always_comb begin
    if (sel) begin
      m_ir = b4.in_ready; m_ov = b4.out_valid; m_done = b4.done;
      m_eu = b4.err_unbalanced; m_eo = b4.err_overflow;
      m_word = b4.out_word; m_addr = {6'b0, b4.out_addr};
    end else begin
      m_ir = b8.in_ready; m_ov = b8.out_valid; m_done = b8.done;
      m_eu = b8.err_unbalanced; m_eo = b8.err_overflow;
      m_word = b8.out_word; m_addr = {2'b0, b8.out_addr};
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_w[$];
  int          exp_a[$];
  logic [15:0] lit_w[$];
  int exp_status;
  int exp_consumed;
  int ordy_mode = 1;
  int gap_max = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int opcode(input u8 c);
    case (c)
      8'h3E: return 0;
      8'h3C: return 1;
      8'h2B: return 2;
      8'h2D: return 3;
      8'h2E: return 4;
      8'h2C: return 5;
      8'h5B: return 6;
      8'h5D: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic u8q s2q(input string s);
    u8q q;
    for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
    return q;
  endfunction

  // Reference: walk the program as a list of nibbles, stop at the first error,
  // append the halt and pad, then cut into 4-nibble words.
  task automatic model(input u8q src, input int cap);
    int nibs[$];
    int depth, op, nd, wv;
    depth = 0;
    exp_w.delete();
    exp_a.delete();
    exp_status = ST_DONE;
    exp_consumed = src.size();
    for (int i = 0; i < src.size(); i++) begin
      op = opcode(src[i]);
      nd = depth + ((op == 6) ? 1 : 0) - ((op == 7) ? 1 : 0);
      if (op == 7 && depth == 0) begin
        exp_status = ST_UNB; exp_consumed = i + 1; break;
      end
      if (op >= 0 && nibs.size() == cap - 1) begin
        exp_status = ST_OVF; exp_consumed = i + 1; break;
      end
      if (i == src.size() - 1 && nd != 0) begin
        exp_status = ST_UNB; exp_consumed = i + 1; break;
      end
      if (op >= 0) nibs.push_back(op);
      depth = nd;
    end
    if (exp_status == ST_DONE) begin
      nibs.push_back(15);
      while (nibs.size() % 4 != 0) nibs.push_back(15);
    end
    for (int w = 0; w < nibs.size() / 4; w++) begin
      wv = (nibs[4*w] << 12) | (nibs[4*w+1] << 8) | (nibs[4*w+2] << 4) | nibs[4*w+3];
      exp_w.push_back(16'(wv));
      exp_a.push_back(w);
    end
  endtask

  task automatic pin(input string name, input u8q src, input int cap, input int st);
    model(src, cap);
    chk({name, "_status"}, 32'(exp_status), 32'(st));
    chk({name, "_nwords"}, 32'(exp_w.size()), 32'(lit_w.size()));
    for (int i = 0; i < lit_w.size() && i < exp_w.size(); i++)
      chk({name, "_word"}, 32'(exp_w[i]), 32'(lit_w[i]));
  endtask

  // out_ready driver, updated after the task-side #1 edits so mode changes apply the same cycle
  initial begin
    forever begin
      @(posedge clock);
      #2;
      case (ordy_mode)
        0:       out_ready = ($urandom_range(0, 2) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: word transfers against the model queue, stall stability, flag exclusion.
  initial begin
    logic pv, pr, prst;
    logic [15:0] pw;
    logic [7:0]  pa;
    pv = 1'b0; pr = 1'b0; prst = 1'b1; pw = '0; pa = '0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        chk("done_err_exclusive", 32'(m_done & (m_eu | m_eo)), 32'd0);
        if (pv && !pr && !prst) begin
          chk("stall_valid", 32'(m_ov), 32'd1);
          chk("stall_word", 32'(m_word), 32'(pw));
          chk("stall_addr", 32'(m_addr), 32'(pa));
          chk("stall_in_ready", 32'(m_ir), 32'd0);
        end
        if (m_ov && out_ready && !reset) begin
          if (exp_w.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_word: got 0x%0h @%0d, want none", m_word, m_addr);
          end else begin
            chk("word", 32'(m_word), 32'(exp_w[0]));
            chk("addr", 32'(m_addr), 32'(exp_a[0]));
            void'(exp_w.pop_front());
            void'(exp_a.pop_front());
          end
        end
        pv = m_ov; pr = out_ready; prst = reset; pw = m_word; pa = m_addr;
      end
    end
  end

  task automatic do_reset(input logic s);
    @(posedge clock); #1;
    reset = 1'b1; sel = s; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_w.delete();
    exp_a.delete();
  endtask

  task automatic send(input u8 b, input logic last);
    int t;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clock); #1; end
    in_data = b; in_valid = 1'b1; in_last = last; t = 0;
    forever begin
      @(negedge clock);
      if (m_ir) break;
      t++;
      if (t > 300) begin
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want 1", t);
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_prog(input u8q src, input logic s, input int mode);
    int t;
    do_reset(s);
    ordy_mode = mode;
    model(src, s ? 16 : 256);
    for (int i = 0; i < exp_consumed; i++) send(src[i], i == src.size() - 1);
    if (exp_status != ST_DONE) begin
      @(negedge clock);
      chk("err_one_cycle", 32'((exp_status == ST_UNB) ? m_eu : m_eo), 32'd1);
    end
    t = 0;
    while (!(m_done | m_eu | m_eo) && t < 3000) begin @(negedge clock); t++; end
    repeat (2) @(negedge clock);
    chk("final_done", 32'(m_done), 32'(exp_status == ST_DONE));
    chk("final_err_unbalanced", 32'(m_eu), 32'(exp_status == ST_UNB));
    chk("final_err_overflow", 32'(m_eo), 32'(exp_status == ST_OVF));
    chk("words_left", 32'(exp_w.size()), 32'd0);
    chk("final_in_ready", 32'(m_ir), 32'd0);
    chk("final_out_valid", 32'(m_ov), 32'd0);
  endtask

  function automatic u8q gen();
    u8q q;
    u8 junk[5] = '{8'h61, 8'h20, 8'h0A, 8'h00, 8'h7A};
    u8 ops[6]  = '{8'h3E, 8'h3C, 8'h2B, 8'h2D, 8'h2E, 8'h2C};
    int len, depth, p;
    len = $urandom_range(1, 30);
    depth = 0;
    for (int i = 0; i < len; i++) begin
      p = $urandom_range(0, 99);
      if (p < 8) q.push_back(junk[$urandom_range(0, 4)]);
      else if (p < 22) begin q.push_back(8'h5B); depth++; end
      else if (p < 36 && (depth > 0 || $urandom_range(0, 9) == 0)) begin
        q.push_back(8'h5D); depth--;
      end else q.push_back(ops[$urandom_range(0, 5)]);
    end
    if ($urandom_range(0, 9) < 8) while (depth > 0) begin q.push_back(8'h5D); depth--; end
    if ($urandom_range(0, 9) < 3) q.push_back(8'h0A);
    return q;
  endfunction

  initial begin
    u8q src;
    #900000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u8q src;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_in_ready", 32'(m_ir), 32'd1);
      chk("rst_out_valid", 32'(m_ov), 32'd0);
      chk("rst_out_word", 32'(m_word), 32'd0);
      chk("rst_out_addr", 32'(m_addr), 32'd0);
      chk("rst_done", 32'(m_done), 32'd0);
      chk("rst_err_unbalanced", 32'(m_eu), 32'd0);
      chk("rst_err_overflow", 32'(m_eo), 32'd0);
    end
    sel = 1'b0;
    mon_en = 1'b1;

    lit_w.delete(); lit_w.push_back(16'h2637); lit_w.push_back(16'h4FFF);
    pin("loop", s2q("+[-]."), 256, ST_DONE);
    run_prog(s2q("+[-]."), 1'b0, 1);

    lit_w.delete(); lit_w.push_back(16'h01FF);
    pin("junk", s2q(">a<\n"), 256, ST_DONE);
    run_prog(s2q(">a<\n"), 1'b0, 1);

    lit_w.delete(); lit_w.push_back(16'h2222); lit_w.push_back(16'hFFFF);
    pin("boundary", s2q("++++"), 256, ST_DONE);
    run_prog(s2q("++++"), 1'b0, 1);

    lit_w.delete();
    pin("close0", s2q("]"), 256, ST_UNB);
    run_prog(s2q("]"), 1'b0, 1);
    pin("open_end", s2q("[+"), 256, ST_UNB);
    run_prog(s2q("[+"), 1'b0, 1);

    src.delete();
    for (int i = 0; i < 15; i++) src.push_back(8'h2B);
    lit_w.delete();
    lit_w.push_back(16'h2222); lit_w.push_back(16'h2222);
    lit_w.push_back(16'h2222); lit_w.push_back(16'h222F);
    pin("fill4", src, 16, ST_DONE);
    run_prog(src, 1'b1, 1);
    src.push_back(8'h2B);
    lit_w.delete();
    lit_w.push_back(16'h2222); lit_w.push_back(16'h2222); lit_w.push_back(16'h2222);
    pin("ovf4", src, 16, ST_OVF);
    run_prog(src, 1'b1, 0);

    src.delete();
    for (int i = 0; i < 260; i++) src.push_back(8'h2B);
    run_prog(src, 1'b0, 0);

    // Stall during EMIT, then reset in the third stalled cycle drops the pending word.
    do_reset(1'b0);
    gap_max = 0;
    ordy_mode = 2;
    exp_w.push_back(16'h2222); exp_a.push_back(0);
    repeat (4) send(8'h2B, 1'b0);
    @(negedge clock);
    chk("valid_after_fill", 32'(m_ov), 32'd1);
    repeat (2) @(negedge clock);
    @(posedge clock); #1 ordy_mode = 1;
    @(posedge clock); #1 ordy_mode = 2;
    exp_w.push_back(16'h2222); exp_a.push_back(1);
    repeat (4) send(8'h2B, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk("stall2_in_ready", 32'(m_ir), 32'd0);
      chk("stall2_addr", 32'(m_addr), 32'd1);
      chk("stall2_word", 32'(m_word), 32'h2222);
    end
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("mid_emit_rst_valid", 32'(m_ov), 32'd0);
    chk("mid_emit_rst_addr", 32'(m_addr), 32'd0);
    chk("mid_emit_rst_in_ready", 32'(m_ir), 32'd1);
    chk("pending_dropped", 32'(exp_w.size()), 32'd1);
    exp_w.delete(); exp_a.delete();

    for (int r = 0; r < 60; r++) begin
      gap_max = $urandom_range(0, 2);
      run_prog(gen(), r[0], $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bf_encoder.md
BF_ENCODER -- requirements
Module: bf_encoder

Interface
REQ-001 Parameter N, default 8: log2 of program capacity in 4-bit opcodes (2**N nibbles, 2**(N-2) words); legal N >= 4.
REQ-002 clock  input  1  sole clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_data  input  8  ASCII source byte.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_last  input  1  byte is final source byte; qualified by in_valid.
REQ-007 in_ready  output  1  encoder accepts byte this cycle.
REQ-008 out_word  output  16  packed opcode word.
REQ-009 out_addr  output  N-2  word address of out_word in code store.
REQ-010 out_valid  output  1  out_word/out_addr valid.
REQ-011 out_ready  input  1  sink accepts word this cycle.
REQ-012 done  output  1  program fully emitted, sticky.
REQ-013 err_unbalanced  output  1  bracket mismatch detected, sticky.
REQ-014 err_overflow  output  1  program exceeds capacity, sticky.

Function
REQ-015 Byte accepted iff in_valid & in_ready at posedge; output word transferred iff out_valid & out_ready.
REQ-016 Opcode map: '>'=0x0, '<'=0x1, '+'=0x2, '-'=0x3, '.'=0x4, ','=0x5, '['=0x6, ']'=0x7; halt/pad nibble = 0xF.
REQ-017 Other bytes (incl. whitespace, NUL) consumed and discarded; no nibble, no state change except in_last handling.
REQ-018 Packing: k-th opcode of a word (k=0..3) placed at out_word[15-4k:12-4k]; first opcode in bits [15:12].
REQ-019 States: FILL, EMIT, FLUSH, DONE, ERROR; reset enters FILL.
REQ-020 FILL: in_ready=1, out_valid=0; accepted opcode writes slot k, k increments, nibble count increments.
REQ-021 Opcode filling slot 3 -> EMIT next cycle; out_valid high one cycle after accepting byte.
REQ-022 EMIT: in_ready=0; out_valid=1; out_word/out_addr held stable until transfer; on transfer out_addr increments, k=0, go to FILL (or FLUSH if last seen).
REQ-023 Bracket depth counter, N bits: '[' +1, ']' -1; ']' at depth 0 -> ERROR with err_unbalanced=1, byte consumed, no nibble.
REQ-024 Opcode accepted when nibble count == 2**N-1 (no room for halt) -> ERROR with err_overflow=1, nibble not stored.
REQ-025 in_last accepted: byte processed first per REQ-017..024; then depth != 0 -> ERROR err_unbalanced=1; else FLUSH (after EMIT completes if word just filled).
REQ-026 FLUSH: pad slots k..3 with 0xF; if k==0 emit 0xFFFF; present via out_valid as in EMIT; on transfer go DONE.
REQ-027 Every completed program ends with at least one 0xF nibble; total nibbles incl. halt <= 2**N.
REQ-028 DONE: done=1, in_ready=0, out_valid=0 until reset.
REQ-029 ERROR: in_ready=0, out_valid=0, flags held until reset; words already transferred are not retracted.
REQ-030 Error and done never both asserted.

Reset
REQ-031 reset asserted: next cycle state=FILL, k=0, nibble count=0, depth=0, out_addr=0, out_word=0, out_valid=0, in_ready=1, done=0, err_unbalanced=0, err_overflow=0.
REQ-032 reset overrides all inputs in the same cycle, including mid-EMIT; pending word is dropped, not transferred.

Verification
REQ-033 "+[-]." with in_last on '.', out_ready=1 -> 0x2637 @addr0, 0x4FFF @addr1, done=1, no errors.
REQ-034 ">a<\n" with in_last on '\n' -> 0x01FF @addr0, done=1.
REQ-035 "++++" in_last on 4th '+' -> 0x2222 @addr0, 0xFFFF @addr1, done=1.
REQ-036 "]" -> err_unbalanced=1 cycle after acceptance, out_valid never asserted; "[+" with in_last -> err_unbalanced=1, no flush word.
REQ-037 N=4: 15 '+' with last -> 0x2222 @0, 0x2222 @1, 0x2222 @2, 0x222F @3, done; 16 '+' -> err_overflow on 16th byte after three words emitted.
REQ-038 out_ready low 5 cycles during EMIT -> out_word/out_addr stable, in_ready=0 throughout; reset asserted in cycle 3 -> out_valid=0, out_addr=0 next cycle.
